// File: rtl/scalar_alu_seq.sv
// Issue/response sequencer around the combinational scalar ALU: registers operands
// into the ALU, captures its result a cycle later and resolves branches and next PC.
module scalar_alu_seq #(
  parameter int DATA_LEN        = 32,
  parameter int SCALAR_REG_LEN  = 64,
  parameter int REG_INDEX_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,

  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_alu_signal,
  input  logic [3:0]                 in_func_code,
  input  logic [SCALAR_REG_LEN-1:0]  in_rs1,
  input  logic [SCALAR_REG_LEN-1:0]  in_rs2,
  input  logic [SCALAR_REG_LEN-1:0]  in_imm,
  input  logic [DATA_LEN-1:0]        in_pc,
  input  logic [REG_INDEX_WIDTH-1:0] in_rd,
  input  logic                       in_is_branch,
  input  logic [1:0]                 in_branch_cond,

  output logic [SCALAR_REG_LEN-1:0]  alu_rs1,
  output logic [SCALAR_REG_LEN-1:0]  alu_rs2,
  output logic [SCALAR_REG_LEN-1:0]  alu_imm,
  output logic [DATA_LEN-1:0]        alu_pc,
  output logic [3:0]                 alu_signal,
  output logic [3:0]                 alu_func_code,
  input  logic [SCALAR_REG_LEN-1:0]  alu_result,
  input  logic [1:0]                 alu_sign_bits,

  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_INDEX_WIDTH-1:0] out_rd,
  output logic                       out_wb_en,
  output logic [SCALAR_REG_LEN-1:0]  out_wb_data,
  output logic                       out_branch_taken,
  output logic [DATA_LEN-1:0]        out_next_pc,
  output logic [1:0]                 out_sign_bits
);

  localparam logic [3:0] ALU_NOP = 4'h0;

  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_LT = 2'b10;
  localparam logic [1:0] COND_GE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic                       accept;
  logic                       capture;
  logic [REG_INDEX_WIDTH-1:0] rd_q;
  logic                       is_branch_q;
  logic [1:0]                 cond_q;
  logic                       res_zero;
  logic                       res_neg;
  logic                       cond_met;
  logic                       taken;
  logic [DATA_LEN-1:0]        pc_offset;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake; flush overrides every other event
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~flush;
        if (!flush && in_valid) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = flush ? IDLE : RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
        if (flush) begin
          state_next = IDLE;
        end else if (out_ready) begin
          state_next = in_valid ? EXEC : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign capture = (state == EXEC) & ~flush;

  // ALU operand registers; the opcode falls back to NOP once the ALU has been sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rs1       <= '0;
      alu_rs2       <= '0;
      alu_imm       <= '0;
      alu_pc        <= '0;
      alu_signal    <= ALU_NOP;
      alu_func_code <= '0;
      rd_q          <= '0;
      is_branch_q   <= 1'b0;
      cond_q        <= COND_EQ;
    end else if (accept) begin
      alu_rs1       <= in_rs1;
      alu_rs2       <= in_rs2;
      alu_imm       <= in_imm;
      alu_pc        <= in_pc;
      alu_signal    <= in_alu_signal;
      alu_func_code <= in_func_code;
      rd_q          <= in_rd;
      is_branch_q   <= in_is_branch;
      cond_q        <= in_branch_cond;
    end else if (state == EXEC || flush) begin
      alu_signal    <= ALU_NOP;
    end
  end

  // Branch conditions come from the subtraction result itself, not the ALU sign bits
  always_comb begin
    res_zero = (alu_result == '0);
    res_neg  = alu_result[SCALAR_REG_LEN-1];
    cond_met = 1'b0;
    case (cond_q)
      COND_EQ: cond_met = res_zero;
      COND_NE: cond_met = ~res_zero;
      COND_LT: cond_met = res_neg;
      COND_GE: cond_met = ~res_neg;
      default: cond_met = 1'b0;
    endcase
    taken     = is_branch_q & cond_met;
    pc_offset = taken ? alu_imm[DATA_LEN-1:0] : DATA_LEN'(4);
  end

  // Response registers, held stable while waiting in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rd           <= '0;
      out_wb_en        <= 1'b0;
      out_wb_data      <= '0;
      out_branch_taken <= 1'b0;
      out_next_pc      <= '0;
      out_sign_bits    <= '0;
    end else if (capture) begin
      out_rd           <= rd_q;
      out_wb_en        <= ~is_branch_q & (rd_q != '0);
      out_wb_data      <= alu_result;
      out_branch_taken <= taken;
      out_next_pc      <= alu_pc + pc_offset;
      out_sign_bits    <= alu_sign_bits;
    end
  end

endmodule

// File: tb/tb_scalar_alu_seq.sv
// Directed bench for scalar_alu_seq with a small behavioural ALU model on the
// operand side and hand-computed expectations on the response side.
module tb_scalar_alu_seq;

  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] FN_ADD   = 4'h0;
  localparam logic [3:0] FN_ADDI  = 4'h1;
  localparam logic [3:0] FN_SUB   = 4'h2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_signal;
  logic [3:0]  in_func_code;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [63:0] in_imm;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_is_branch;
  logic [1:0]  in_branch_cond;
  logic [63:0] alu_rs1;
  logic [63:0] alu_rs2;
  logic [63:0] alu_imm;
  logic [31:0] alu_pc;
  logic [3:0]  alu_signal;
  logic [3:0]  alu_func_code;
  logic [63:0] alu_result;
  logic [1:0]  alu_sign_bits;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [63:0] out_wb_data;
  logic        out_branch_taken;
  logic [31:0] out_next_pc;
  logic [1:0]  out_sign_bits;

  int n_asserts = 0;
  int n_fail    = 0;

  scalar_alu_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_signal    (in_alu_signal),
    .in_func_code     (in_func_code),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_imm           (in_imm),
    .in_pc            (in_pc),
    .in_rd            (in_rd),
    .in_is_branch     (in_is_branch),
    .in_branch_cond   (in_branch_cond),
    .alu_rs1          (alu_rs1),
    .alu_rs2          (alu_rs2),
    .alu_imm          (alu_imm),
    .alu_pc           (alu_pc),
    .alu_signal       (alu_signal),
    .alu_func_code    (alu_func_code),
    .alu_result       (alu_result),
    .alu_sign_bits    (alu_sign_bits),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rd           (out_rd),
    .out_wb_en        (out_wb_en),
    .out_wb_data      (out_wb_data),
    .out_branch_taken (out_branch_taken),
    .out_next_pc      (out_next_pc),
    .out_sign_bits    (out_sign_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU
  always_comb begin
    alu_result = '0;
    if (alu_signal == OP_ALU) begin
      case (alu_func_code)
        FN_ADD:  alu_result = alu_rs1 + alu_rs2;
        FN_ADDI: alu_result = alu_rs1 + alu_imm;
        FN_SUB:  alu_result = alu_rs1 - alu_rs2;
        default: alu_result = '0;
      endcase
    end
    alu_sign_bits = {alu_result[63], alu_result == '0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] func, input logic [63:0] rs1,
                               input logic [63:0] rs2, input logic [63:0] imm,
                               input logic [31:0] pc, input logic [4:0] rd,
                               input logic is_br, input logic [1:0] cond);
    in_valid       = 1'b1;
    in_alu_signal  = OP_ALU;
    in_func_code   = func;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_imm         = imm;
    in_pc          = pc;
    in_rd          = rd;
    in_is_branch   = is_br;
    in_branch_cond = cond;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_alu_signal  = OP_NOP;
    in_func_code   = '0;
    in_rs1         = '0;
    in_rs2         = '0;
    in_imm         = '0;
    in_pc          = '0;
    in_rd          = '0;
    in_is_branch   = 1'b0;
    in_branch_cond = '0;
    out_ready      = 1'b1;

    $display("[TB] reset state");
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_alu_signal", 64'(alu_signal), 64'(OP_NOP));
    checkOutput("rst_wb_data", out_wb_data, 64'd0);
    checkOutput("rst_next_pc", 64'(out_next_pc), 64'd0);
    #9;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] ADD 5+7 -> x3");
    applyStimulus(FN_ADD, 64'd5, 64'd7, 64'd0, 32'h1000, 5'd3, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    checkOutput("add_alu_rs1", alu_rs1, 64'd5);
    checkOutput("add_alu_signal", 64'(alu_signal), 64'(OP_ALU));
    checkOutput("add_valid_e0", 64'(out_valid), 64'd0);
    checkOutput("add_in_ready_exec", 64'(in_ready), 64'd0);
    tick();
    checkOutput("add_valid_e1", 64'(out_valid), 64'd1);
    checkOutput("add_wb_data", out_wb_data, 64'd12);
    checkOutput("add_wb_en", 64'(out_wb_en), 64'd1);
    checkOutput("add_rd", 64'(out_rd), 64'd3);
    checkOutput("add_next_pc", 64'(out_next_pc), 64'h1004);
    checkOutput("add_taken", 64'(out_branch_taken), 64'd0);
    checkOutput("add_alu_nop_resp", 64'(alu_signal), 64'(OP_NOP));
    tick();
    checkOutput("add_retired", 64'(out_valid), 64'd0);

    $display("[TB] BLT / BGE with rs1=-1 rs2=2");
    applyStimulus(FN_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h40, 32'h100, 5'd5, 1'b1, 2'b10);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("blt_taken", 64'(out_branch_taken), 64'd1);
    checkOutput("blt_next_pc", 64'(out_next_pc), 64'h140);
    checkOutput("blt_wb_en", 64'(out_wb_en), 64'd0);
    checkOutput("blt_wb_data", out_wb_data, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();
    applyStimulus(FN_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h40, 32'h100, 5'd5, 1'b1, 2'b11);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("bge_taken", 64'(out_branch_taken), 64'd0);
    checkOutput("bge_next_pc", 64'(out_next_pc), 64'h104);
    tick();
    applyStimulus(FN_SUB, 64'd9, 64'd9, 64'h20, 32'h200, 5'd0, 1'b1, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("beq_taken", 64'(out_branch_taken), 64'd1);
    checkOutput("beq_next_pc", 64'(out_next_pc), 64'h220);
    tick();
    applyStimulus(FN_SUB, 64'd9, 64'd9, 64'h20, 32'h200, 5'd0, 1'b1, 2'b01);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("bne_taken", 64'(out_branch_taken), 64'd0);
    checkOutput("bne_next_pc", 64'(out_next_pc), 64'h204);
    tick();

    $display("[TB] backpressure then back-to-back accept");
    out_ready = 1'b0;
    applyStimulus(FN_ADD, 64'd100, 64'd23, 64'd0, 32'h300, 5'd7, 1'b0, 2'b00);
    tick();
    applyStimulus(FN_ADDI, 64'd10, 64'd0, 64'd20, 32'h400, 5'd9, 1'b0, 2'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_wb_data", out_wb_data, 64'd123);
      checkOutput("bp_rd", 64'(out_rd), 64'd7);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_retired", 64'(out_valid), 64'd0);
    checkOutput("bp_new_alu_rs1", alu_rs1, 64'd10);
    checkOutput("bp_new_alu_imm", alu_imm, 64'd20);
    tick();
    checkOutput("bp_new_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_new_wb_data", out_wb_data, 64'd30);
    checkOutput("bp_new_rd", 64'(out_rd), 64'd9);
    checkOutput("bp_new_next_pc", 64'(out_next_pc), 64'h404);
    tick();

    $display("[TB] flush in EXEC");
    applyStimulus(FN_ADD, 64'd1, 64'd1, 64'd0, 32'h500, 5'd4, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flx_valid", 64'(out_valid), 64'd0);
    checkOutput("flx_alu_nop", 64'(alu_signal), 64'(OP_NOP));
    tick();
    checkOutput("flx_valid_later", 64'(out_valid), 64'd0);
    checkOutput("flx_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] flush in RESP with a new request");
    out_ready = 1'b0;
    applyStimulus(FN_ADD, 64'd2, 64'd3, 64'd0, 32'h600, 5'd6, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("flr_valid_before", 64'(out_valid), 64'd1);
    applyStimulus(FN_ADD, 64'd77, 64'd1, 64'd0, 32'h700, 5'd8, 1'b0, 2'b00);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checkOutput("flr_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flr_valid", 64'(out_valid), 64'd0);
    checkOutput("flr_not_accepted", alu_rs1, 64'd2);
    checkOutput("flr_alu_nop", 64'(alu_signal), 64'(OP_NOP));
    tick();
    checkOutput("flr_valid_later", 64'(out_valid), 64'd0);

    $display("[TB] PC wrap and rd=0");
    applyStimulus(FN_ADD, 64'd4, 64'd4, 64'd0, 32'hFFFF_FFFC, 5'd1, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("wrap_next_pc", 64'(out_next_pc), 64'd0);
    checkOutput("wrap_wb_en", 64'(out_wb_en), 64'd1);
    tick();
    applyStimulus(FN_ADDI, 64'd4, 64'd0, 64'd11, 32'h800, 5'd0, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("rd0_wb_en", 64'(out_wb_en), 64'd0);
    checkOutput("rd0_wb_data", out_wb_data, 64'd15);
    tick();

    $display("[TB] async reset in RESP");
    out_ready = 1'b0;
    applyStimulus(FN_ADD, 64'd40, 64'd2, 64'd0, 32'h900, 5'd2, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("ar_valid_before", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_wb_data", out_wb_data, 64'd0);
    checkOutput("ar_alu_rs1", alu_rs1, 64'd0);
    checkOutput("ar_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("ar_no_resp", 64'(out_valid), 64'd0);
    checkOutput("ar_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
